// File: rtl/hyperram_rx_capture.sv
// HyperRAM read-data capture: qualifies DDR beats by RWDS, packs 16-bit words,
// tracks burst length and a no-data timeout, and buffers words in a small FIFO.
module hyperram_rx_capture #(
  parameter int DQ_W       = 8,
  parameter int LEN_W      = 8,
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DQ_W-1:0]   din_ris,
  input  logic [DQ_W-1:0]   din_fal,
  input  logic              rwds_ris,
  input  logic              rwds_fal,
  output logic [2*DQ_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  state_t              state_r;
  logic [LEN_W-1:0]    remaining_r;
  logic [TMR_W-1:0]    timer_r;
  logic                busy_r;
  logic                done_r;
  logic                timeout_r;
  logic                overflow_r;

  logic [2*DQ_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [2*DQ_W-1:0]   dout_r;
  logic                dout_valid_r;

  logic                beat_s;
  logic                capture_s;
  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;
  logic [2*DQ_W-1:0]   word_s;
  logic [CNT_W-1:0]    count_nxt_s;
  logic [PTR_W-1:0]    rd_nxt_s;
  logic [2*DQ_W-1:0]   head_nxt_s;

  // Beat qualification, FIFO push/pop decisions and next head-of-queue word
  always_comb begin
    beat_s      = rwds_ris & ~rwds_fal;
    word_s      = {din_ris, din_fal};
    capture_s   = beat_s & ((state_r == WAIT_DATA) | (state_r == CAPTURE));
    full_s      = (count_r == DEPTH_C);
    pop_s       = dout_valid_r & dout_ready;
    push_s      = capture_s & (~full_s | pop_s);
    drop_s      = capture_s & full_s & ~pop_s;
    count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    rd_nxt_s    = rd_ptr_r + PTR_W'(pop_s);
    // When the queue drains to nothing but this push, the new word becomes the head.
    if (count_nxt_s == CNT_W'(0)) begin
      head_nxt_s = dout_r;
    end else if (count_r == CNT_W'(pop_s)) begin
      head_nxt_s = word_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Burst control FSM with registered status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      remaining_r <= LEN_W'(0);
      timer_r     <= TMR_W'(0);
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (len != LEN_W'(0)) begin
              state_r     <= WAIT_DATA;
              remaining_r <= len;
              timer_r     <= TMR_W'(0);
              overflow_r  <= 1'b0;
              busy_r      <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        WAIT_DATA, CAPTURE: begin
          if (drop_s) begin
            overflow_r <= 1'b1;
          end
          if (beat_s) begin
            timer_r <= TMR_W'(0);
            if (remaining_r <= LEN_W'(1)) begin
              remaining_r <= LEN_W'(0);
              state_r     <= IDLE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              remaining_r <= remaining_r - LEN_W'(1);
              state_r     <= CAPTURE;
            end
          end else if (timer_r == TMR_LAST) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
            timer_r   <= TMR_W'(0);
          end else if (timer_r != TMR_MAX) begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output FIFO storage, pointers and registered head word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {(2*DQ_W){1'b0}};
      end
      wr_ptr_r     <= PTR_W'(0);
      rd_ptr_r     <= PTR_W'(0);
      count_r      <= CNT_W'(0);
      dout_r       <= {(2*DQ_W){1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= word_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r     <= rd_nxt_s;
      count_r      <= count_nxt_s;
      dout_r       <= head_nxt_s;
      dout_valid_r <= (count_nxt_s != CNT_W'(0));
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign timeout    = timeout_r;
  assign overflow   = overflow_r;

endmodule
